// File: rtl/fantasticfft_pkg.sv
// Shared types and constants for the fantasticfft datapath blocks.
package fantasticfft_pkg;

  // Signed Q8.8 sample: bit 7 is the sign/integer MSB, bit -8 the finest fraction.
  typedef logic signed [7:-8] fixed_t;

  // Points per FFT frame and the matching index width.
  localparam int FFT_N = 8;
  localparam int IDX_W = 3;

  // Loader control states.
  typedef enum logic [0:0] {
    FILL      = 1'b0,
    FULL_WAIT = 1'b1
  } loader_state_t;

endpackage

// File: rtl/fantasticfft_fft8_loader.sv
// Serial-to-parallel front end for the FFT8 stage: collects 8 streamed Q8.8
// samples into an input buffer and hands complete frames to a one-frame
// output slot, so streaming can continue while a frame waits downstream.
module fantasticfft_fft8_loader
  import fantasticfft_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_sample,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      x0,
  output logic [DATA_W-1:0]      x1,
  output logic [DATA_W-1:0]      x2,
  output logic [DATA_W-1:0]      x3,
  output logic [DATA_W-1:0]      x4,
  output logic [DATA_W-1:0]      x5,
  output logic [DATA_W-1:0]      x6,
  output logic [DATA_W-1:0]      x7,
  output logic                   isValid,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  loader_state_t    state;
  loader_state_t    state_next;
  logic [IDX_W-1:0] wr_idx;
  fixed_t           sample_buf [FFT_N];
  fixed_t           x_q        [FFT_N];

  logic accept;
  logic last_sample;
  logic slot_free;
  logic out_fire;
  logic load_from_fill;
  logic load_from_wait;
  logic in_ready_next;

  // Handshake qualifiers; a flush cancels any accept in the same cycle.
  always_comb begin
    accept      = in_valid && in_ready && !flush;
    last_sample = (wr_idx == IDX_W'(FFT_N - 1));
    slot_free   = !isValid || out_ready;
    out_fire    = isValid && out_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: park in FULL_WAIT when a frame completes but the slot is busy.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL: begin
          if (accept && last_sample && !slot_free) begin
            state_next = FULL_WAIT;
          end
        end
        FULL_WAIT: begin
          if (out_fire) begin
            state_next = FILL;
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  // Control outputs: which source loads the output slot, and next in_ready.
  always_comb begin
    load_from_fill = 1'b0;
    load_from_wait = 1'b0;
    in_ready_next  = (state_next == FILL);
    if (!flush) begin
      case (state)
        FILL:      load_from_fill = accept && last_sample && slot_free;
        FULL_WAIT: load_from_wait = out_fire;
        default:   load_from_fill = 1'b0;
      endcase
    end
  end

  // in_ready is registered so it can be driven straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= in_ready_next;
    end
  end

  // Input buffer: each accepted sample lands at the current write index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FFT_N; i++) begin
        sample_buf[i] <= '0;
      end
    end else if (accept && state == FILL) begin
      sample_buf[wr_idx] <= fixed_t'(in_sample);
    end
  end

  // Write index: cleared by flush or frame transfer, otherwise advances per accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
    end else if (flush || load_from_fill || load_from_wait) begin
      wr_idx <= '0;
    end else if (accept && state == FILL) begin
      wr_idx <= wr_idx + IDX_W'(1);
    end
  end

  // Output slot: loads a new frame or drains on handshake, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FFT_N; i++) begin
        x_q[i] <= '0;
      end
      isValid <= 1'b0;
    end else if (load_from_fill) begin
      for (int i = 0; i < FFT_N - 1; i++) begin
        x_q[i] <= sample_buf[i];
      end
      x_q[FFT_N-1] <= fixed_t'(in_sample);
      isValid      <= 1'b1;
    end else if (load_from_wait) begin
      for (int i = 0; i < FFT_N; i++) begin
        x_q[i] <= sample_buf[i];
      end
      isValid <= 1'b1;
    end else if (out_fire) begin
      isValid <= 1'b0;
    end
  end

  // Delivered-frame counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (out_fire) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];
  assign x4 = x_q[4];
  assign x5 = x_q[5];
  assign x6 = x_q[6];
  assign x7 = x_q[7];

endmodule

// File: tb/tb_fantasticfft_fft8_loader.sv
// Directed self-checking bench for the FFT8 loader.
module tb_fantasticfft_fft8_loader;

  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_sample;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              out_ready;
  logic [DATA_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic              isValid;
  logic [15:0]       frame_cnt;

  logic              in_ready2;
  logic [DATA_W-1:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic              isValid2;
  logic [1:0]        frame_cnt2;

  int totalChecks  = 0;
  int passedChecks = 0;
  int failedChecks = 0;

  fantasticfft_fft8_loader #(.DATA_W(DATA_W), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .isValid(isValid), .frame_cnt(frame_cnt)
  );

  fantasticfft_fft8_loader #(.DATA_W(DATA_W), .FRAME_CNT_W(2)) dutWrap (
    .clk(clk), .rst_n(rst_n), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready2), .flush(flush), .out_ready(out_ready),
    .x0(w0), .x1(w1), .x2(w2), .x3(w3), .x4(w4), .x5(w5), .x6(w6), .x7(w7),
    .isValid(isValid2), .frame_cnt(frame_cnt2)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q8.8 constant from an integer value.
  function automatic logic [15:0] q88(input int v);
    return 16'(v * 256);
  endfunction

  function automatic logic [15:0] getX(input int k);
    case (k)
      0: return x0;
      1: return x1;
      2: return x2;
      3: return x3;
      4: return x4;
      5: return x5;
      6: return x6;
      default: return x7;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) passedChecks++;
    else begin
      failedChecks++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample with in_valid for a single edge.
  task automatic applyStimulus(input logic [15:0] v);
    in_valid  = 1'b1;
    in_sample = v;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic resetDut();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic checkFrame(input string tag, input int firstVal);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("%s_x%0d", tag, k), 32'(getX(k)), 32'(q88(firstVal + k)));
    end
  endtask

  initial begin
    int ySum;
    int yAlt;
    int pulses;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset values while rst_n is held low.
    #3;
    checkOutput("rst_isValid", 32'(isValid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_x0", 32'(x0), 32'd0);
    checkOutput("rst_x7", 32'(x7), 32'd0);
    tick();
    checkOutput("rst_hold_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Full-rate frame 1.0..8.0 with out_ready high.
    $display("[TB] full-rate frame");
    for (int i = 1; i <= 7; i++) begin
      in_valid  = 1'b1;
      in_sample = q88(i);
      tick();
    end
    checkOutput("full_before_8th", 32'(isValid), 32'd0);
    in_sample = q88(8);
    tick();
    in_valid = 1'b0;
    checkOutput("full_isValid", 32'(isValid), 32'd1);
    checkFrame("full", 1);
    ySum = 0;
    yAlt = 0;
    for (int k = 0; k < 8; k++) begin
      ySum += int'($signed(getX(k)));
      yAlt += (k % 2 == 0) ? int'($signed(getX(k))) : -int'($signed(getX(k)));
    end
    checkOutput("fft_y0", 32'(ySum), 32'(36 * 256));
    checkOutput("fft_y4", 32'(yAlt), 32'(-4 * 256));
    tick();
    checkOutput("full_pulse_end", 32'(isValid), 32'd0);
    checkOutput("full_frame_cnt", 32'(frame_cnt), 32'd1);

    // Backpressure: 16 samples with out_ready low.
    $display("[TB] backpressure");
    resetDut();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(q88(17 + i));
    checkOutput("bp_frame1_valid", 32'(isValid), 32'd1);
    checkFrame("bp_f1", 17);
    for (int i = 0; i < 7; i++) applyStimulus(q88(25 + i));
    checkOutput("bp_in_ready_15", 32'(in_ready), 32'd1);
    applyStimulus(q88(32));
    checkOutput("bp_in_ready_16", 32'(in_ready), 32'd0);
    checkFrame("bp_f1_held", 17);
    checkOutput("bp_frame_cnt_held", 32'(frame_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp_drain_valid", 32'(isValid), 32'd1);
    checkFrame("bp_f2", 25);
    checkOutput("bp_drain_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_drain_frame_cnt", 32'(frame_cnt), 32'd1);
    tick();
    checkOutput("bp_hold2_valid", 32'(isValid), 32'd1);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_final_valid", 32'(isValid), 32'd0);
    checkOutput("bp_final_frame_cnt", 32'(frame_cnt), 32'd2);

    // Flush after 3 samples, then a fresh frame 9.0..16.0.
    $display("[TB] flush");
    resetDut();
    for (int i = 1; i <= 3; i++) applyStimulus(q88(i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 7; i++) applyStimulus(q88(9 + i));
    checkOutput("flush_not_early", 32'(isValid), 32'd0);
    applyStimulus(q88(16));
    checkOutput("flush_valid", 32'(isValid), 32'd1);
    checkFrame("flush", 9);

    // Flush coinciding with an accept drops that sample.
    in_valid  = 1'b1;
    in_sample = q88(127);
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(q88(33 + i));
    checkOutput("flushacc_not_early", 32'(isValid), 32'd0);
    applyStimulus(q88(40));
    checkOutput("flushacc_valid", 32'(isValid), 32'd1);
    checkFrame("flushacc", 33);

    // Gapped input: one sample every other cycle.
    $display("[TB] gapped input");
    resetDut();
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(q88(i));
      pulses += int'(isValid);
      if (i == 8) begin
        checkOutput("gap_valid_after_8th", 32'(isValid), 32'd1);
        checkFrame("gap", 1);
      end
      tick();
      pulses += int'(isValid);
    end
    checkOutput("gap_pulse_count", 32'(pulses), 32'd1);

    // Asynchronous reset mid-frame, with a held frame on the outputs.
    $display("[TB] async reset");
    resetDut();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(q88(50 + i));
    for (int i = 0; i < 5; i++) applyStimulus(q88(60 + i));
    checkOutput("arst_pre_valid", 32'(isValid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_isValid", 32'(isValid), 32'd0);
    checkOutput("arst_x0", 32'(x0), 32'd0);
    checkOutput("arst_x7", 32'(x7), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) applyStimulus(q88(3 + i));
    checkOutput("arst_next_valid", 32'(isValid), 32'd1);
    checkFrame("arst_next", 3);

    // Five back-to-back frames: 16-bit counter reads 5, 2-bit counter wraps to 1.
    $display("[TB] frame counter wrap");
    resetDut();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) begin
        in_valid  = 1'b1;
        in_sample = q88(f * 8 + i + 1);
        tick();
      end
    end
    in_valid = 1'b0;
    checkOutput("wrap_last_valid", 32'(isValid), 32'd1);
    checkFrame("wrap_last", 33);
    tick();
    checkOutput("wrap_cnt16", 32'(frame_cnt), 32'd5);
    checkOutput("wrap_cnt2", 32'(frame_cnt2), 32'd1);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
